// File: rtl/float_accumulator_sp.sv
// Single-precision running accumulator: a five-state sequencer walks each accepted
// addend through align, add, normalise and pack (truncating, saturating) against the held sum.
module float_accumulator_sp #(
  parameter int DATA_W = 32
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_VALID,
  input  logic [DATA_W-1:0] i_FLOAT_WORD,
  input  logic              i_INVALID,
  input  logic              i_CLEAR,
  output logic              o_READY,
  output logic [DATA_W-1:0] o_ACC_WORD,
  output logic              o_DONE,
  output logic              o_OVERFLOW,
  output logic [15:0]       o_COUNT
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK} state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [DATA_W-1:0]  addend_p0;
  logic               inv_p0;
  logic               sign_a_p1, sign_b_p1;
  logic [7:0]         exp_p1;
  logic [23:0]        sig_a_p1, sig_b_p1;
  logic               sign_p2;
  logic [7:0]         exp_p2;
  logic [24:0]        sum_p2;
  logic               sign_p3, zero_p3;
  logic signed [9:0]  exp_p3;
  logic [23:0]        man_p3;

  logic [7:0]         exp_a, exp_b, exp_big;
  logic [23:0]        al_a, al_b;
  logic               sgn_add;
  logic [24:0]        sum_add;
  logic [4:0]         lz;
  logic signed [9:0]  exp_norm;
  logic [23:0]        man_norm;
  logic [32:0]        packed_res;

  function automatic logic [23:0] unpack_sig(input logic [31:0] w);
    return (w[30:23] == 8'd0) ? 24'd0 : {1'b1, w[22:0]};
  endfunction

  function automatic logic [23:0] shr_sig(input logic [23:0] s, input logic [7:0] d);
    return (d >= 8'd24) ? 24'd0 : (s >> d);
  endfunction

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc24 = 5'(23 - i);
  endfunction

  // Returns {overflow, word}: truncated result, flushed to +0 on underflow, clamped to max finite.
  function automatic logic [32:0] sat_pack(input logic sgn, input logic signed [9:0] e,
                                           input logic [22:0] m, input logic z);
    if (z || e <= 10'sd0)
      return 33'd0;
    if (e >= 10'sd255)
      return {1'b1, sgn, 31'h7F7FFFFF};
    return {1'b0, sgn, e[7:0], m};
  endfunction

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N || i_CLEAR)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_READY = (state_q == IDLE) && i_RST_N && !i_CLEAR;
    accept  = i_VALID && o_READY;
  end

  // Stage p1: align the smaller-exponent significand to the larger exponent
  always_comb begin
    exp_a = o_ACC_WORD[30:23];
    exp_b = addend_p0[30:23];
    if (exp_a >= exp_b) begin
      exp_big = exp_a;
      al_a    = unpack_sig(o_ACC_WORD);
      al_b    = shr_sig(unpack_sig(addend_p0), exp_a - exp_b);
    end else begin
      exp_big = exp_b;
      al_a    = shr_sig(unpack_sig(o_ACC_WORD), exp_b - exp_a);
      al_b    = unpack_sig(addend_p0);
    end
  end

  // Stage p2: signed-magnitude add; exact cancellation gives +0
  always_comb begin
    if (sign_a_p1 == sign_b_p1) begin
      sum_add = {1'b0, sig_a_p1} + {1'b0, sig_b_p1};
      sgn_add = sign_a_p1;
    end else if (sig_a_p1 >= sig_b_p1) begin
      sum_add = {1'b0, sig_a_p1 - sig_b_p1};
      sgn_add = sign_a_p1;
    end else begin
      sum_add = {1'b0, sig_b_p1 - sig_a_p1};
      sgn_add = sign_b_p1;
    end
    if (sum_add == 25'd0)
      sgn_add = 1'b0;
  end

  // Stage p3: single-cycle normalise, exponent widened to signed 10 bits
  always_comb begin
    lz = lzc24(sum_p2[23:0]);
    if (sum_p2[24]) begin
      man_norm = sum_p2[24:1];
      exp_norm = signed'({2'b00, exp_p2}) + 10'sd1;
    end else begin
      man_norm = sum_p2[23:0] << lz;
      exp_norm = signed'({2'b00, exp_p2}) - signed'({5'b00000, lz});
    end
  end

  always_comb packed_res = sat_pack(sign_p3, exp_p3, man_p3[22:0], zero_p3);

  always_ff @(posedge i_CLK) begin
    if (accept) begin
      addend_p0 <= i_INVALID ? '0 : i_FLOAT_WORD;
      inv_p0    <= i_INVALID;
    end
    if (state_q == ALIGN) begin
      sign_a_p1 <= o_ACC_WORD[31];
      sign_b_p1 <= addend_p0[31];
      exp_p1    <= exp_big;
      sig_a_p1  <= al_a;
      sig_b_p1  <= al_b;
    end
    if (state_q == ADD) begin
      sign_p2 <= sgn_add;
      exp_p2  <= exp_p1;
      sum_p2  <= sum_add;
    end
    if (state_q == NORM) begin
      sign_p3 <= sign_p2;
      exp_p3  <= exp_norm;
      man_p3  <= man_norm;
      zero_p3 <= (sum_p2 == 25'd0);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N || i_CLEAR) begin
      o_ACC_WORD <= '0;
      o_DONE     <= 1'b0;
      o_OVERFLOW <= 1'b0;
      o_COUNT    <= 16'd0;
    end else begin
      o_DONE <= (state_q == PACK);
      if (accept)
        o_COUNT <= o_COUNT + 16'd1;
      if (state_q == PACK && !inv_p0) begin
        o_ACC_WORD <= packed_res[31:0];
        if (packed_res[32])
          o_OVERFLOW <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_float_accumulator_sp.sv
// Randomised and directed bench for float_accumulator_sp against an integer-arithmetic
// model of align-truncate, add, normalise and truncating pack.
module tb_float_accumulator_sp;

  logic        i_CLK = 1'b0;
  logic        i_RST_N = 1'b0;
  logic        i_VALID = 1'b0;
  logic [31:0] i_FLOAT_WORD = '0;
  logic        i_INVALID = 1'b0;
  logic        i_CLEAR = 1'b0;
  logic        o_READY;
  logic [31:0] o_ACC_WORD;
  logic        o_DONE;
  logic        o_OVERFLOW;
  logic [15:0] o_COUNT;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_acc;
  logic        m_ovf;
  logic [15:0] m_cnt;

  float_accumulator_sp #(.DATA_W(32)) dut (
    .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_VALID(i_VALID), .i_FLOAT_WORD(i_FLOAT_WORD),
    .i_INVALID(i_INVALID), .i_CLEAR(i_CLEAR), .o_READY(o_READY), .o_ACC_WORD(o_ACC_WORD),
    .o_DONE(o_DONE), .o_OVERFLOW(o_OVERFLOW), .o_COUNT(o_COUNT)
  );

  always #5 i_CLK = ~i_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Sum of two values, each sig * 2^(exp-150), computed on the grid of the larger exponent.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, output logic ovf);
    longint va, vb, s, mag;
    int ea, eb, e, er;
    logic sg;
    ovf = 1'b0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    va = (ea == 0) ? 64'sd0 : longint'({1'b1, a[22:0]});
    vb = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]});
    e  = (ea > eb) ? ea : eb;
    va = (e - ea >= 24) ? 64'sd0 : (va >> (e - ea));
    vb = (e - eb >= 24) ? 64'sd0 : (vb >> (e - eb));
    s  = (a[31] ? -va : va) + (b[31] ? -vb : vb);
    if (s == 0) return 32'h0;
    sg  = (s < 0);
    mag = sg ? -s : s;
    er  = e;
    while (mag >= 64'sd16777216) begin mag = mag / 2; er++; end
    while (mag < 64'sd8388608) begin mag = mag * 2; er--; end
    if (er <= 0) return 32'h0;
    if (er >= 255) begin ovf = 1'b1; return {sg, 31'h7F7FFFFF}; end
    return {sg, 8'(er), mag[22:0]};
  endfunction

  task automatic model_apply(input logic [31:0] w, input bit inv);
    logic o;
    if (!inv) begin
      m_acc = ref_add(m_acc, w, o);
      m_ovf = m_ovf | o;
    end
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic model_clear();
    m_acc = 32'h0; m_ovf = 1'b0; m_cnt = 16'd0;
  endtask

  // Offers one word, returns cycles from accepting edge to o_DONE (-1 if none) and the new sum.
  task automatic do_add(input logic [31:0] w, input bit inv, output int lat, output logic [31:0] acc);
    @(negedge i_CLK);
    for (int k = 0; k < 20 && !o_READY; k++) @(negedge i_CLK);
    i_VALID = 1'b1; i_FLOAT_WORD = w; i_INVALID = inv;
    @(posedge i_CLK); #1;
    i_VALID = 1'b0; i_INVALID = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge i_CLK); #1;
      if (o_DONE) begin lat = k; break; end
    end
    acc = o_ACC_WORD;
  endtask

  task automatic pulse_clear();
    @(negedge i_CLK); i_CLEAR = 1'b1;
    @(negedge i_CLK); i_CLEAR = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    i_RST_N = 1'b0;
    repeat (3) @(posedge i_CLK);
    @(negedge i_CLK);
    checks++; if (o_READY !== 1'b0) begin errors++; $display("FAIL rst_ready_low got %b want 0", o_READY); end
    checks++; if (o_ACC_WORD !== 32'h0) begin errors++; $display("FAIL rst_acc got %h want 00000000", o_ACC_WORD); end
    checks++; if (o_DONE !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", o_DONE); end
    checks++; if (o_OVERFLOW !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", o_OVERFLOW); end
    checks++; if (o_COUNT !== 16'h0) begin errors++; $display("FAIL rst_count got %h want 0000", o_COUNT); end
    i_RST_N = 1'b1; #1;
    checks++; if (o_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", o_READY); end
    model_clear();
  endtask

  task automatic test_basic();
    int lat; logic [31:0] acc;
    do_add(32'h3F800000, 1'b0, lat, acc); model_apply(32'h3F800000, 1'b0);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_lat1 got %0d want 4", lat); end
    checks++; if (acc !== 32'h3F800000) begin errors++; $display("FAIL basic_acc1 got %h want 3f800000", acc); end
    do_add(32'h40000000, 1'b0, lat, acc); model_apply(32'h40000000, 1'b0);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_lat2 got %0d want 4", lat); end
    checks++; if (acc !== 32'h40400000) begin errors++; $display("FAIL basic_acc2 got %h want 40400000", acc); end
    checks++; if (o_COUNT !== 16'd2) begin errors++; $display("FAIL basic_count got %0d want 2", o_COUNT); end
  endtask

  task automatic test_cancel();
    int lat; logic [31:0] acc;
    pulse_clear();
    do_add(32'h3F800000, 1'b0, lat, acc); model_apply(32'h3F800000, 1'b0);
    do_add(32'hBF800000, 1'b0, lat, acc); model_apply(32'hBF800000, 1'b0);
    checks++; if (acc !== 32'h0) begin errors++; $display("FAIL cancel_acc got %h want 00000000", acc); end
    checks++; if (o_OVERFLOW !== 1'b0) begin errors++; $display("FAIL cancel_ovf got %b want 0", o_OVERFLOW); end
  endtask

  task automatic test_truncate();
    int lat; logic [31:0] acc;
    pulse_clear();
    do_add(32'h4B800000, 1'b0, lat, acc); model_apply(32'h4B800000, 1'b0);
    do_add(32'h3F800000, 1'b0, lat, acc); model_apply(32'h3F800000, 1'b0);
    checks++; if (acc !== 32'h4B800000) begin errors++; $display("FAIL trunc_acc got %h want 4b800000", acc); end
    do_add(32'h3FC00000, 1'b0, lat, acc); model_apply(32'h3FC00000, 1'b0);
    checks++; if (acc !== 32'h4B800000) begin errors++; $display("FAIL trunc_acc2 got %h want 4b800000", acc); end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] acc;
    pulse_clear();
    do_add(32'h7F7FFFFF, 1'b0, lat, acc); model_apply(32'h7F7FFFFF, 1'b0);
    checks++; if (o_OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", o_OVERFLOW); end
    do_add(32'h7F7FFFFF, 1'b0, lat, acc); model_apply(32'h7F7FFFFF, 1'b0);
    checks++; if (acc !== 32'h7F7FFFFF) begin errors++; $display("FAIL ovf_acc got %h want 7f7fffff", acc); end
    checks++; if (o_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", o_OVERFLOW); end
    do_add(32'hFF7FFFFF, 1'b0, lat, acc); model_apply(32'hFF7FFFFF, 1'b0);
    checks++; if (acc !== 32'h0) begin errors++; $display("FAIL ovf_sub_acc got %h want 00000000", acc); end
    checks++; if (o_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", o_OVERFLOW); end
  endtask

  task automatic test_invalid_stream();
    int lat; logic [31:0] acc, acc0; logic [15:0] cnt0;
    int done_cyc[$];
    pulse_clear();
    do_add(32'h41200000, 1'b0, lat, acc); model_apply(32'h41200000, 1'b0);
    acc0 = o_ACC_WORD; cnt0 = o_COUNT;
    @(negedge i_CLK);
    i_VALID = 1'b1; i_INVALID = 1'b1; i_FLOAT_WORD = $urandom | 32'h40000000;
    for (int c = 1; c <= 25; c++) begin
      @(posedge i_CLK); #1;
      if (o_DONE) done_cyc.push_back(c);
    end
    i_VALID = 1'b0; i_INVALID = 1'b0;
    for (int i = 0; i < 5; i++) model_apply(32'h0, 1'b1);
    checks++; if (done_cyc.size() !== 5) begin errors++; $display("FAIL inv_done_count got %0d want 5", done_cyc.size()); end
    for (int i = 0; i < done_cyc.size() && i < 5; i++) begin
      checks++;
      if (done_cyc[i] !== 5 * (i + 1)) begin errors++; $display("FAIL inv_done_cycle got %0d want %0d", done_cyc[i], 5 * (i + 1)); end
    end
    checks++; if (o_ACC_WORD !== acc0) begin errors++; $display("FAIL inv_acc got %h want %h", o_ACC_WORD, acc0); end
    checks++; if (o_COUNT !== cnt0 + 16'd5) begin errors++; $display("FAIL inv_count got %0d want %0d", o_COUNT, cnt0 + 16'd5); end
  endtask

  task automatic test_clear_abort();
    int lat; logic [31:0] acc; int dones;
    do_add(32'h40A00000, 1'b0, lat, acc); model_apply(32'h40A00000, 1'b0);
    checks++; if (o_OVERFLOW !== m_ovf) begin errors++; $display("FAIL clr_pre_ovf got %b want %b", o_OVERFLOW, m_ovf); end
    @(negedge i_CLK); i_VALID = 1'b1; i_FLOAT_WORD = 32'h3F800000;
    @(posedge i_CLK); #1; i_VALID = 1'b0;
    @(posedge i_CLK);
    @(posedge i_CLK); #1;
    i_CLEAR = 1'b1; #1;
    checks++; if (o_READY !== 1'b0) begin errors++; $display("FAIL clr_ready_low got %b want 0", o_READY); end
    @(posedge i_CLK); #1;
    i_CLEAR = 1'b0; #1;
    model_clear();
    checks++; if (o_ACC_WORD !== 32'h0) begin errors++; $display("FAIL clr_acc got %h want 00000000", o_ACC_WORD); end
    checks++; if (o_COUNT !== 16'h0) begin errors++; $display("FAIL clr_count got %0d want 0", o_COUNT); end
    checks++; if (o_OVERFLOW !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", o_OVERFLOW); end
    checks++; if (o_READY !== 1'b1) begin errors++; $display("FAIL clr_ready got %b want 1", o_READY); end
    dones = 0;
    for (int c = 0; c < 6; c++) begin @(posedge i_CLK); #1; if (o_DONE) dones++; end
    checks++; if (dones !== 0) begin errors++; $display("FAIL clr_no_done got %0d want 0", dones); end
    @(negedge i_CLK); i_VALID = 1'b1; i_CLEAR = 1'b1; i_FLOAT_WORD = 32'h40000000;
    @(posedge i_CLK); #1; i_VALID = 1'b0; i_CLEAR = 1'b0;
    dones = 0;
    for (int c = 0; c < 6; c++) begin @(posedge i_CLK); #1; if (o_DONE) dones++; end
    checks++; if (dones !== 0) begin errors++; $display("FAIL clr_drop_done got %0d want 0", dones); end
    checks++; if (o_COUNT !== 16'h0) begin errors++; $display("FAIL clr_drop_count got %0d want 0", o_COUNT); end
    checks++; if (o_ACC_WORD !== 32'h0) begin errors++; $display("FAIL clr_drop_acc got %h want 00000000", o_ACC_WORD); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] acc; int dones;
    do_add(32'h3F800000, 1'b0, lat, acc); model_apply(32'h3F800000, 1'b0);
    @(negedge i_CLK); i_VALID = 1'b1; i_FLOAT_WORD = 32'h40000000;
    @(posedge i_CLK); #1; i_VALID = 1'b0;
    @(posedge i_CLK); #1;
    i_RST_N = 1'b0; #1;
    checks++; if (o_READY !== 1'b0) begin errors++; $display("FAIL rab_ready_low got %b want 0", o_READY); end
    @(posedge i_CLK); #1;
    i_RST_N = 1'b1; #1;
    model_clear();
    checks++; if (o_READY !== 1'b1) begin errors++; $display("FAIL rab_ready got %b want 1", o_READY); end
    checks++; if (o_ACC_WORD !== 32'h0) begin errors++; $display("FAIL rab_acc got %h want 00000000", o_ACC_WORD); end
    checks++; if (o_COUNT !== 16'h0) begin errors++; $display("FAIL rab_count got %0d want 0", o_COUNT); end
    dones = 0;
    for (int c = 0; c < 6; c++) begin @(posedge i_CLK); #1; if (o_DONE) dones++; end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rab_no_done got %0d want 0", dones); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] acc, w; bit inv; int r;
    pulse_clear();
    for (int n = 0; n < 40; n++) begin
      r   = $urandom_range(0, 19);
      inv = ($urandom_range(0, 7) == 0);
      w   = {1'(($urandom_range(0, 1))), 8'($urandom_range(118, 136)), 23'($urandom)};
      if (r == 0) w = {1'(($urandom_range(0, 1))), 8'h00, 23'($urandom) | 23'h1};
      else if (r == 1 && m_acc != 32'h0) w = m_acc ^ 32'h80000000;
      do_add(w, inv, lat, acc);
      model_apply(w, inv);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rand_lat[%0d] got %0d want 4", n, lat); end
      checks++; if (acc !== m_acc) begin errors++; $display("FAIL rand_acc[%0d] word %h got %h want %h", n, w, acc, m_acc); end
    end
    checks++; if (o_COUNT !== m_cnt) begin errors++; $display("FAIL rand_count got %0d want %0d", o_COUNT, m_cnt); end
    checks++; if (o_OVERFLOW !== m_ovf) begin errors++; $display("FAIL rand_ovf got %b want %b", o_OVERFLOW, m_ovf); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_cancel();
    test_truncate();
    test_overflow();
    test_clear_abort();
    test_invalid_stream();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_accumulator_sp.md
FLOAT_ACCUMULATOR_SP -- requirements
Module: float_accumulator_sp

Interface
REQ-001 SHALL have port i_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port i_VALID, input, 1 bit: i_FLOAT_WORD/i_INVALID carry a word this cycle.
REQ-004 SHALL have port i_FLOAT_WORD, input, 32 bits: IEEE-754 single-precision addend from the upstream fixed-to-float stage.
REQ-005 SHALL have port i_INVALID, input, 1 bit: upstream zero flag; when high, the word is treated as +0.
REQ-006 SHALL have port i_CLEAR, input, 1 bit: synchronous accumulator clear.
REQ-007 SHALL have port o_READY, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port o_ACC_WORD, output, 32 bits: running single-precision sum.
REQ-009 SHALL have port o_DONE, output, 1 bit: one-cycle pulse marking an o_ACC_WORD update.
REQ-010 SHALL have port o_OVERFLOW, output, 1 bit: sticky saturation flag.
REQ-011 SHALL have port o_COUNT, output, 16 bits: count of accepted words.

Function
REQ-012 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, PACK; transitions IDLE->ALIGN on accept, then ALIGN->ADD->NORM->PACK->IDLE unconditionally, one cycle each.
REQ-013 SHALL drive o_READY = (state==IDLE) & i_RST_N & ~i_CLEAR; accept = i_VALID & o_READY.
REQ-014 SHALL, on accept, register the addend (forced to +0 if i_INVALID) and increment o_COUNT modulo 2^16 (0xFFFF -> 0x0000).
REQ-015 SHALL treat operands with exponent 0 as +0 (denormals flushed); NaN/Inf inputs are out of scope and produce undefined results.
REQ-016 ALIGN: SHALL right-shift the 24-bit significand (hidden bit included) of the smaller-exponent operand by the exponent difference, discarding shifted-out bits; difference >= 24 yields 0.
REQ-017 ADD: equal signs -> magnitudes added (25-bit); unequal signs -> smaller magnitude subtracted from larger, result sign = sign of larger; exact cancellation -> +0.
REQ-018 NORM: SHALL normalise in one cycle: carry-out -> shift right 1, exponent +1; else shift left by leading-zero count, exponent minus count; result exponent computed at 10 bits signed.
REQ-019 PACK: SHALL truncate (round toward zero) to 23 mantissa bits; exponent <= 0 -> +0; exponent >= 255 -> saturate to {sign,0x7F7FFFFF} and set o_OVERFLOW.
REQ-020 SHALL update o_ACC_WORD and pulse o_DONE high on the edge leaving PACK: o_DONE is high exactly 4 cycles after the accepting edge; throughput 1 word per 5 cycles.
REQ-021 SHALL, for an i_INVALID word, still run the full pipeline, pulse o_DONE at the same latency, and leave o_ACC_WORD unchanged.
REQ-022 SHALL hold o_OVERFLOW high until i_CLEAR or reset, independent of later results.
REQ-023 i_CLEAR in any state SHALL abort any in-flight addition, set o_ACC_WORD=0, o_OVERFLOW=0, o_COUNT=0, o_DONE=0, state=IDLE; it has priority over i_VALID (same-cycle word dropped, not counted).
REQ-024 SHALL ignore i_VALID outside IDLE (upstream holds its word until o_READY).

Reset
REQ-025 With i_RST_N low at a rising edge: state=IDLE, o_ACC_WORD=0x00000000, o_DONE=0, o_OVERFLOW=0, o_COUNT=0; o_READY=0 while i_RST_N is low.
REQ-026 Reset mid-operation SHALL discard the in-flight word with no o_DONE pulse; o_READY=1 in the first cycle after i_RST_N returns high.

Verification
REQ-027 Reset; accept 0x3F800000, then 0x40000000 -> o_DONE 4 cycles after each accept; o_ACC_WORD 0x3F800000 then 0x40400000; o_COUNT=2.
REQ-028 Accumulator 0x3F800000, add 0xBF800000 -> o_ACC_WORD=0x00000000, o_OVERFLOW=0.
REQ-029 Accumulator 0x4B800000 (2^24), add 0x3F800000 -> o_ACC_WORD remains 0x4B800000 (truncated).
REQ-030 Accumulator 0x7F7FFFFF, add 0x7F7FFFFF -> o_ACC_WORD=0x7F7FFFFF, o_OVERFLOW=1; subsequent add of 0xFF7FFFFF leaves o_OVERFLOW=1.
REQ-031 i_VALID held high with i_INVALID=1 -> o_DONE pulses every 5 cycles, o_ACC_WORD unchanged, o_COUNT increments each accept.
REQ-032 Assert i_CLEAR during NORM, and separately drop i_RST_N during ADD -> no o_DONE pulse; o_ACC_WORD=0, o_COUNT=0; o_READY=1 on the following cycle.
